program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter BASE_ADDR, default 8'd0: instruction-memory word address of the first loaded word.
REQ-002 Parameter HOLD_AFTER_DONE, default 0: 1 keeps cpu_hold asserted after completion until the next start.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to begin a load; sampled in IDLE only.
REQ-006 in_valid  input  1  byte-stream source has a byte on in_byte.
REQ-007 in_byte  input  8  stream byte.
REQ-008 in_ready  output  1  loader accepts in_byte this cycle; a transfer occurs when in_valid and in_ready are both high at a posedge.
REQ-009 mem_address  output  8  instruction-memory word address.
REQ-010 mem_write  output  1  one-cycle write strobe to instruction memory.
REQ-011 mem_write_data  output  32  word to write.
REQ-012 mem_mode  output  1  0 while loading (memory write-enabled mode), 1 otherwise.
REQ-013 cpu_hold  output  1  stalls processor PC update while high.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse at load completion.
REQ-016 error  output  1  sticky load-failure flag.

Function
REQ-017 FSM states: IDLE, COUNT, DATA, WRITE, (CHECK), FIN.
REQ-018 IDLE: in_ready=0; start=1 -> COUNT, clears error, word index and byte counter; asserts cpu_hold and mem_mode=0 from the next cycle.
REQ-019 COUNT: in_ready=1; the accepted byte N sets the word total to N+1 (1..256) -> DATA.
REQ-020 DATA: in_ready=1; bytes packed big-endian (first byte -> [31:24]); the 4th accepted byte -> WRITE.
REQ-021 WRITE: lasts exactly one cycle; in_ready=0, mem_write=1, mem_address=(BASE_ADDR+index) mod 256, mem_write_data=the packed word.
REQ-022 Latency: the 4th byte accepted at edge k produces mem_write high in the cycle after edge k.
REQ-023 After WRITE: if more words remain -> DATA with index+1; otherwise -> CHECK when compiled in, else FIN.
REQ-024 FIN: done=1 for one cycle; cpu_hold drops unless HOLD_AFTER_DONE=1; mem_mode=1 -> IDLE.
REQ-025 Address wrap: index arithmetic is 8-bit; BASE_ADDR=8'hFE with 3 words writes to FE, FF, 00.
REQ-026 in_valid low stalls the FSM in place with no state or counter change; gaps of any length are legal.
REQ-027 start while busy is ignored.
REQ-028 mem_write never asserts outside WRITE.
REQ-029 mem_write_data holds its last value outside WRITE.

Reset
REQ-030 rst low immediately forces IDLE with in_ready=0, mem_write=0, mem_address=0, mem_write_data=0, mem_mode=1, cpu_hold=0, busy=0, done=0, error=0.
REQ-031 Reset mid-load discards any partial word; words already written are not rolled back.

Configuration
REQ-032 Macro LOADER_CHECKSUM_EN defined: after the last WRITE the FSM enters CHECK (in_ready=1) and accepts one byte.
REQ-033 With LOADER_CHECKSUM_EN, error=1 if the CHECK byte is not the XOR of every prior byte, including the count byte; done still pulses.
REQ-034 LOADER_CHECKSUM_EN undefined: no CHECK state; error is tied 0.

Structure
REQ-035 Shared package loader_pkg holds the state enum, BYTES_PER_WORD=4 and MEM_DEPTH=256.
REQ-036 One sub-module, byte_packer: a shift register with a 2-bit byte counter that outputs a 32-bit word and a word_ready flag.

Verification
REQ-037 Count byte 8'h01, bytes 04 23 F7 80 AA BB CC DD -> writes [BASE]=0423F780 and [BASE+1]=AABBCCDD, then done pulse; cpu_hold high throughout.
REQ-038 in_valid toggled every other cycle on the same stream -> identical writes; no mem_write while in_valid is low.
REQ-039 BASE_ADDR=8'hFE, count 8'h02 -> writes to addresses FE, FF, 00 in order.
REQ-040 rst pulsed low after 2 data bytes, then a fresh start and a full stream -> no write from the partial word; the new load starts at BASE_ADDR.
REQ-041 LOADER_CHECKSUM_EN, stream 00 11 22 33 44 with check byte 44 -> error=0; check byte 45 -> error=1 with the done pulse.
REQ-042 start asserted during DATA -> no effect; the load completes normally.

Source files
------------

// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the program loader.
//   state_e        loader FSM states
//   BYTES_PER_WORD bytes packed into one instruction word
//   MEM_DEPTH      instruction-memory depth in words
package loader_pkg;
   typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CHECK, S_FIN} state_e;
   localparam int BYTES_PER_WORD = 4;
   localparam int MEM_DEPTH = 256;
endpackage

// File: rtl/program_loader_byte_packer.sv
// byte_packer: big-endian byte-to-word shift register for the program loader.
//   clk, rst       clock, asynchronous active-low reset
//   clr_i          restart packing at byte 0
//   en_i           a byte is accepted this cycle
//   byte_i         accepted byte
//   word_o         packed word, first byte in [31:24], current byte in [7:0]
//   word_ready_o   the current byte completes a word
module byte_packer
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_ready_o
);
   logic [23:0] sr_q;
   logic [1:0]  cnt_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else if (clr_i) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else if (en_i) begin
         sr_q  <= {sr_q[15:0], byte_i};
         cnt_q <= cnt_q + 2'd1;
      end
   // The last byte is folded in combinationally so the word can be written
   // on the same edge that accepts it.
   assign word_o       = {sr_q, byte_i};
   assign word_ready_o = en_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/program_loader.sv
// program_loader: loads a counted byte stream into instruction memory as 32-bit words.
//   Parameters: BASE_ADDR (first word address), HOLD_AFTER_DONE (keep cpu_hold after completion)
//   clk, rst                 clock, asynchronous active-low reset
//   start                    begin a load (sampled in IDLE only)
//   in_valid, in_byte        byte stream; in_ready accepts it
//   mem_address, mem_write, mem_write_data   instruction-memory write port
//   mem_mode                 0 while loading, 1 otherwise
//   cpu_hold                 stalls the processor during a load
//   busy, done, error        status; done pulses once per load, error is sticky
//   Build option LOADER_CHECKSUM_EN: a trailing XOR checksum byte is verified.
module program_loader
   import loader_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR       = 8'd0,
   parameter bit         HOLD_AFTER_DONE = 1'b0
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_byte,
   output logic        in_ready,
   output logic [7:0]  mem_address,
   output logic        mem_write,
   output logic [31:0] mem_write_data,
   output logic        mem_mode,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        error
);
   localparam int AW = $clog2(MEM_DEPTH);
   state_e        state_q;
   logic [AW-1:0] idx_q, last_q;
   logic          in_ready_q, mem_write_q, mem_mode_q, cpu_hold_q, busy_q, done_q;
   logic [7:0]    mem_address_q;
   logic [31:0]   mem_write_data_q;
   logic [31:0]   word;
   logic          word_ready;
   byte_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (state_q == S_IDLE && start),
      .en_i         (state_q == S_DATA && in_valid),
      .byte_i       (in_byte),
      .word_o       (word),
      .word_ready_o (word_ready)
   );
`ifdef LOADER_CHECKSUM_EN
   logic [7:0] xor_q;
   logic       error_q;
`endif
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q          <= S_IDLE;
         idx_q            <= '0;
         last_q           <= '0;
         in_ready_q       <= 1'b0;
         mem_write_q      <= 1'b0;
         mem_address_q    <= '0;
         mem_write_data_q <= '0;
         mem_mode_q       <= 1'b1;
         cpu_hold_q       <= 1'b0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         xor_q            <= '0;
         error_q          <= 1'b0;
`endif
      end else begin
         mem_write_q <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            S_IDLE: if (start) begin
               state_q    <= S_COUNT;
               idx_q      <= '0;
               in_ready_q <= 1'b1;
               mem_mode_q <= 1'b0;
               cpu_hold_q <= 1'b1;
               busy_q     <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
               xor_q      <= '0;
               error_q    <= 1'b0;
`endif
            end
            // The count byte is the index of the last word (total = N+1).
            S_COUNT: if (in_valid) begin
               state_q <= S_DATA;
               last_q  <= in_byte;
`ifdef LOADER_CHECKSUM_EN
               xor_q   <= xor_q ^ in_byte;
`endif
            end
            S_DATA: if (in_valid) begin
`ifdef LOADER_CHECKSUM_EN
               xor_q <= xor_q ^ in_byte;
`endif
               if (word_ready) begin
                  state_q          <= S_WRITE;
                  in_ready_q       <= 1'b0;
                  mem_write_q      <= 1'b1;
                  mem_address_q    <= BASE_ADDR + idx_q;
                  mem_write_data_q <= word;
               end
            end
            S_WRITE: if (idx_q != last_q) begin
               state_q    <= S_DATA;
               idx_q      <= idx_q + 1'b1;
               in_ready_q <= 1'b1;
            end else begin
`ifdef LOADER_CHECKSUM_EN
               state_q    <= S_CHECK;
               in_ready_q <= 1'b1;
`else
               state_q    <= S_FIN;
               done_q     <= 1'b1;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: if (in_valid) begin
               state_q    <= S_FIN;
               in_ready_q <= 1'b0;
               done_q     <= 1'b1;
               error_q    <= in_byte != xor_q;
            end
`endif
            S_FIN: begin
               state_q    <= S_IDLE;
               mem_mode_q <= 1'b1;
               cpu_hold_q <= HOLD_AFTER_DONE;
               busy_q     <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   assign in_ready       = in_ready_q;
   assign mem_address    = mem_address_q;
   assign mem_write      = mem_write_q;
   assign mem_write_data = mem_write_data_q;
   assign mem_mode       = mem_mode_q;
   assign cpu_hold       = cpu_hold_q;
   assign busy           = busy_q;
   assign done           = done_q;
`ifdef LOADER_CHECKSUM_EN
   assign error = error_q;
`else
   assign error = 1'b0;
`endif
endmodule
